// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared cpu/ram types and the arbiter grant record
package cpu_types_pkg;
   localparam int WORD_W = 32;
   localparam int NCPUS  = 2;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

   typedef struct packed {
      logic [$clog2(NCPUS)-1:0] core;
      logic                     is_d;
   } arb_grant_t;
endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - first requesting core at or after the round-robin pointer
module rr_picker #(
   parameter int CPUS = 2,
   parameter int CW   = $clog2(CPUS)
) (
   input  logic [CPUS-1:0] req,
   input  logic [CW-1:0]   ptr,
   output logic            valid,
   output logic [CW-1:0]   idx
);
   // Scan from farthest offset to nearest so the core closest to ptr wins last.
   always_comb begin
      int c;
      valid = 1'b0;
      idx   = '0;
      c     = 0;
      for (int i = CPUS - 1; i >= 0; i--) begin
         c = (int'(ptr) + i) % CPUS;
         if (req[c[CW-1:0]]) begin
            valid = 1'b1;
            idx   = c[CW-1:0];
         end
      end
   end
endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one RAM port among per-core icache/dcache requesters
module mem_bus_arbiter
   import cpu_types_pkg::*;
#(
   parameter int CPUS   = NCPUS,
   parameter int ADDR_W = WORD_W
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic [CPUS-1:0]   iREN,
   input  logic [ADDR_W-1:0] iaddr [CPUS],
   output logic [CPUS-1:0]   iwait,
   output word_t             iload [CPUS],
   input  logic [CPUS-1:0]   dREN,
   input  logic [CPUS-1:0]   dWEN,
   input  logic [ADDR_W-1:0] daddr [CPUS],
   input  word_t             dstore [CPUS],
   output logic [CPUS-1:0]   dwait,
   output word_t             dload [CPUS],
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output word_t             ramstore,
   input  word_t             ramload,
   input  ramstate_t         ramstate
);
   localparam int CW = $clog2(CPUS);

   typedef enum logic {IDLE, SERVE} state_t;

   state_t          state, state_n;
   arb_grant_t      grant, grant_n;
   logic [CW-1:0]   rr_ptr, rr_ptr_n;
   logic [CPUS-1:0] dreq;
   logic            pick_valid;
   logic [CW-1:0]   pick_idx;
   logic            granted_req;

   assign dreq        = dREN | dWEN;
   assign granted_req = grant.is_d ? dreq[grant.core] : iREN[grant.core];

   rr_picker #(.CPUS(CPUS), .CW(CW)) u_picker (
      .req   (iREN | dreq),
      .ptr   (rr_ptr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state  <= IDLE;
         grant  <= '0;
         rr_ptr <= '0;
      end else begin
         state  <= state_n;
         grant  <= grant_n;
         rr_ptr <= rr_ptr_n;
      end
   end

   always_comb begin
      state_n  = state;
      grant_n  = grant;
      rr_ptr_n = rr_ptr;
      iwait    = '1;
      dwait    = '1;
      for (int c = 0; c < CPUS; c++) begin
         iload[c] = '0;
         dload[c] = '0;
      end
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;

      case (state)
         IDLE: begin
            if (pick_valid) begin
               state_n      = SERVE;
               grant_n.core = pick_idx;
               grant_n.is_d = dreq[pick_idx];
            end
         end
         SERVE: begin
            // RAM follows the granted cache's live inputs; a dropped request disables it.
            if (grant.is_d) begin
               ramWEN   = dWEN[grant.core];
               ramREN   = dREN[grant.core] & ~dWEN[grant.core];
               ramaddr  = daddr[grant.core];
               ramstore = dstore[grant.core];
            end else begin
               ramREN   = iREN[grant.core];
               ramaddr  = iaddr[grant.core];
            end

            if (!granted_req) begin
               state_n = IDLE;
            end else if (ramstate == ACCESS) begin
               state_n  = IDLE;
               rr_ptr_n = CW'((int'(grant.core) + 1) % CPUS);
               if (grant.is_d) begin
                  dwait[grant.core] = 1'b0;
                  dload[grant.core] = ramload;
               end else begin
                  iwait[grant.core] = 1'b0;
                  iload[grant.core] = ramload;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end
endmodule
